// File: rtl/hdmi_axi_rd_engine.sv
// Line-read request engine: splits one kick/read_addr/read_num request into 4KB-safe AXI4 INCR
// read bursts and streams returned beats into the pixel line FIFO. Optional macro: HDMI_AXI_RD_ERR_EN.
module hdmi_axi_rd_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  kick,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [NUM_WIDTH-1:0]  read_num,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    input  logic                  fifo_full
`ifdef HDMI_AXI_RD_ERR_EN
    ,
    output logic                  rd_err,
    output logic [15:0]           rd_err_cnt
`endif
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int CNT_W      = ((NUM_WIDTH > 13) ? NUM_WIDTH : 13) + 1;
    localparam logic [CNT_W-1:0]      MAX_BURST_C = CNT_W'(MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~(ADDR_WIDTH'(BYTES - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic [DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
    logic                  fifo_wr_en_q, fifo_wr_en_d;

    logic [CNT_W-1:0]      room_s;
    logic [CNT_W-1:0]      rem_s;
    logic [CNT_W-1:0]      beats_s;
    logic [8:0]            burst_beats_s;
    logic [ADDR_WIDTH-1:0] addr_step_s;
    logic                  rready_s;
    logic                  r_hs_s;

`ifdef HDMI_AXI_RD_ERR_EN
    logic                  rd_err_q, rd_err_d;
    logic [15:0]           rd_err_cnt_q, rd_err_cnt_d;
`else
    logic                  unused_rresp_s;
    assign unused_rresp_s = ^m_axi_rresp;
`endif

    assign rready_s = (state_q == ST_R) && !fifo_full;
    assign r_hs_s   = m_axi_rvalid && rready_s;

    // Burst sizing: limited by remaining beats, MAX_BURST and the distance to the next 4KB page.
    always_comb begin
        room_s        = CNT_W'((13'h1000 - {1'b0, addr_q[11:0]}) >> BYTE_SHIFT);
        rem_s         = CNT_W'(remaining_q);
        beats_s       = (rem_s < MAX_BURST_C) ? rem_s : MAX_BURST_C;
        beats_s       = (room_s < beats_s) ? room_s : beats_s;
        burst_beats_s = {1'b0, arlen_q} + 9'd1;
        addr_step_s   = ADDR_WIDTH'(burst_beats_s) << BYTE_SHIFT;
    end

    // Next-state and output logic of the request FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        busy_d       = busy_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        fifo_din_d   = fifo_din_q;
        fifo_wr_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (kick) begin
                    addr_d      = read_addr & ALIGN_MASK;
                    remaining_d = read_num;
                    busy_d      = 1'b1;
                    state_d     = ST_AR;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_AR: begin
                if (!arvalid_q) begin
                    // A zero-length request ends here without ever raising arvalid.
                    if (remaining_q == {NUM_WIDTH{1'b0}}) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        araddr_d  = addr_q;
                        arlen_d   = 8'(beats_s - CNT_W'(1));
                        arvalid_d = 1'b1;
                    end
                end else if (m_axi_arready) begin
                    arvalid_d   = 1'b0;
                    addr_d      = addr_q + addr_step_s;
                    remaining_d = remaining_q - NUM_WIDTH'(burst_beats_s);
                    state_d     = ST_R;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_R: begin
                if (r_hs_s) begin
                    fifo_din_d   = m_axi_rdata;
                    fifo_wr_en_d = 1'b1;
                    if (m_axi_rlast) begin
                        if (remaining_q != {NUM_WIDTH{1'b0}}) begin
                            state_d = ST_AR;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_R;
                    end
                end else begin
                    state_d = ST_R;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
    end

`ifdef HDMI_AXI_RD_ERR_EN
    // Sticky error flag and saturating count of non-OKAY beats.
    always_comb begin
        rd_err_d     = rd_err_q;
        rd_err_cnt_d = rd_err_cnt_q;
        if (r_hs_s && (m_axi_rresp != 2'b00)) begin
            rd_err_d     = 1'b1;
            rd_err_cnt_d = (rd_err_cnt_q != 16'hFFFF) ? (rd_err_cnt_q + 16'd1) : rd_err_cnt_q;
        end else begin
            rd_err_d     = rd_err_q;
        end
    end

    // Error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err_q     <= 1'b0;
            rd_err_cnt_q <= 16'd0;
        end else begin
            rd_err_q     <= rd_err_d;
            rd_err_cnt_q <= rd_err_cnt_d;
        end
    end

    assign rd_err     = rd_err_q;
    assign rd_err_cnt = rd_err_cnt_q;
`endif

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            remaining_q  <= {NUM_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            araddr_q     <= {ADDR_WIDTH{1'b0}};
            arlen_q      <= 8'd0;
            arvalid_q    <= 1'b0;
            fifo_din_q   <= {DATA_WIDTH{1'b0}};
            fifo_wr_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            busy_q       <= busy_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
        end
    end

    assign busy          = busy_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(BYTE_SHIFT);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_s;
    assign fifo_din      = fifo_din_q;
    assign fifo_wr_en    = fifo_wr_en_q;

endmodule

// File: tb/tb_hdmi_axi_rd_engine.sv
// Directed bench for hdmi_axi_rd_engine: table of line requests with hand-computed AR streams,
// plus sequences for zero length, FIFO back-pressure, ignored kick and mid-request reset.
module tb_hdmi_axi_rd_engine;

    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kick;
    logic [31:0] read_addr;
    logic [15:0] read_num;
    logic        busy;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
`ifdef HDMI_AXI_RD_ERR_EN
    logic        rd_err;
    logic [15:0] rd_err_cnt;
`endif

    hdmi_axi_rd_engine dut (
        .clk(clk), .rst_n(rst_n), .kick(kick), .read_addr(read_addr), .read_num(read_num),
        .busy(busy), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full)
`ifdef HDMI_AXI_RD_ERR_EN
        , .rd_err(rd_err), .rd_err_cnt(rd_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic [15:0]      num;
        int               n_ar;
        logic [3:0][31:0] ar_addr;
        logic [3:0][7:0]  ar_len;
        int               n_wr;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          kick_cyc = 0;
    int          ar_cnt = 0;
    int          wr_cnt = 0;
    int          busy_cnt = 0;
    int          first_arv_cyc = -1;
    int          fall_cyc = 0;
    int          last_rlast_cyc = 0;
    logic [31:0] ar_addr_log[16];
    logic [7:0]  ar_len_log[16];
    int          q_len[$];
    int          beats_left = 0;
    logic [31:0] seq = 32'd0;
    logic [31:0] exp_seq = 32'd0;
    bit          prev_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI slave / FIFO observer: samples pre-edge values of DUT outputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            q_len.delete();
            beats_left = 0;
            exp_seq    = seq;
            prev_busy  = 1'b0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_cnt < 16) begin
                    ar_addr_log[ar_cnt] = m_axi_araddr;
                    ar_len_log[ar_cnt]  = m_axi_arlen;
                end
                ar_cnt++;
                q_len.push_back(int'(m_axi_arlen) + 1);
            end
            if (m_axi_arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
            if (m_axi_rvalid && m_axi_rready) begin
                beats_left--;
                seq = seq + 32'd1;
                if (m_axi_rlast) last_rlast_cyc = cyc;
            end
            if (fifo_wr_en) begin
                chk("fifo_din", {32'd0, fifo_din}, {32'd0, BASE + exp_seq});
                exp_seq = exp_seq + 32'd1;
                wr_cnt++;
            end
            if (busy) busy_cnt++;
            if (prev_busy && !busy) fall_cyc = cyc;
            prev_busy = busy;
        end
        cyc++;
    end

    // R channel driver: streams the outstanding burst, every odd beat flagged SLVERR.
    always @(negedge clk) begin
        if (beats_left == 0 && q_len.size() > 0) beats_left = q_len.pop_front();
        m_axi_rvalid = (beats_left > 0);
        m_axi_rdata  = BASE + seq;
        m_axi_rlast  = (beats_left == 1);
        m_axi_rresp  = seq[0] ? 2'b10 : 2'b00;
    end

    task automatic set_vec(input int i, input logic [31:0] a, input logic [15:0] n, input int nar,
                           input logic [31:0] a0, input logic [7:0] l0,
                           input logic [31:0] a1, input logic [7:0] l1,
                           input logic [31:0] a2, input logic [7:0] l2,
                           input logic [31:0] a3, input logic [7:0] l3, input int nwr);
        vecs[i].addr = a; vecs[i].num = n; vecs[i].n_ar = nar; vecs[i].n_wr = nwr;
        vecs[i].ar_addr[0] = a0; vecs[i].ar_len[0] = l0;
        vecs[i].ar_addr[1] = a1; vecs[i].ar_len[1] = l1;
        vecs[i].ar_addr[2] = a2; vecs[i].ar_len[2] = l2;
        vecs[i].ar_addr[3] = a3; vecs[i].ar_len[3] = l3;
    endtask

    task automatic clear_logs();
        ar_cnt = 0; wr_cnt = 0; busy_cnt = 0; first_arv_cyc = -1;
        fall_cyc = 0; last_rlast_cyc = 0;
    endtask

    task automatic do_kick(input logic [31:0] a, input logic [15:0] n);
        @(negedge clk);
        kick = 1'b1; read_addr = a; read_num = n; kick_cyc = cyc;
        @(negedge clk);
        kick = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, busy still %0b after %0d cycles", name, busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL wait_writes: got %0d writes, expected at least %0d", wr_cnt, target);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},    {63'd0, busy}, 64'd0);
        chk({tag, "_arvalid"}, {63'd0, m_axi_arvalid}, 64'd0);
        chk({tag, "_araddr"},  {32'd0, m_axi_araddr}, 64'd0);
        chk({tag, "_arlen"},   {56'd0, m_axi_arlen}, 64'd0);
        chk({tag, "_rready"},  {63'd0, m_axi_rready}, 64'd0);
        chk({tag, "_wr_en"},   {63'd0, fifo_wr_en}, 64'd0);
        chk({tag, "_din"},     {32'd0, fifo_din}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        clear_logs();
        do_kick(v.addr, v.num);
        wait_idle($sformatf("v%0d_idle", idx));
        chk($sformatf("v%0d_n_ar", idx), 64'(ar_cnt), 64'(v.n_ar));
        for (int k = 0; k < v.n_ar && k < ar_cnt && k < 4; k++) begin
            chk($sformatf("v%0d_araddr%0d", idx, k), {32'd0, ar_addr_log[k]}, {32'd0, v.ar_addr[k]});
            chk($sformatf("v%0d_arlen%0d", idx, k), {56'd0, ar_len_log[k]}, {56'd0, v.ar_len[k]});
        end
        chk($sformatf("v%0d_n_wr", idx), 64'(wr_cnt), 64'(v.n_wr));
        chk($sformatf("v%0d_kick_to_arvalid", idx), 64'(first_arv_cyc - kick_cyc), 64'd2);
        chk($sformatf("v%0d_busy_fall", idx), 64'(fall_cyc - last_rlast_cyc), 64'd1);
    endtask

    initial begin
        int hits;
        rst_n = 1'b0; kick = 1'b0; read_addr = 32'd0; read_num = 16'd0;
        m_axi_arready = 1'b1; fifo_full = 1'b0;

        set_vec(0, 32'h0000_1000, 16'd64, 4, 32'h1000, 8'd15, 32'h1040, 8'd15,
                32'h1080, 8'd15, 32'h10C0, 8'd15, 64);
        set_vec(1, 32'h0000_0FF8, 16'd8, 2, 32'h0FF8, 8'd1, 32'h1000, 8'd5,
                32'h0, 8'd0, 32'h0, 8'd0, 8);
        set_vec(2, 32'h0000_0FFB, 16'd3, 2, 32'h0FF8, 8'd1, 32'h1000, 8'd0,
                32'h0, 8'd0, 32'h0, 8'd0, 3);
        set_vec(3, 32'h0000_2000, 16'd5, 1, 32'h2000, 8'd4, 32'h0, 8'd0,
                32'h0, 8'd0, 32'h0, 8'd0, 5);
        set_vec(4, 32'hFFFF_FFF0, 16'd6, 2, 32'hFFFF_FFF0, 8'd3, 32'h0000_0000, 8'd1,
                32'h0, 8'd0, 32'h0, 8'd0, 6);
        set_vec(5, 32'h0000_3000, 16'd17, 2, 32'h3000, 8'd15, 32'h3040, 8'd0,
                32'h0, 8'd0, 32'h0, 8'd0, 17);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("arsize", {61'd0, m_axi_arsize}, 64'd2);
        chk("arburst", {62'd0, m_axi_arburst}, 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Zero-length request: one busy cycle, no AR.
        clear_logs();
        do_kick(32'h0000_4000, 16'd0);
        repeat (8) @(negedge clk);
        chk("zero_busy_cycles", 64'(busy_cnt), 64'd1);
        chk("zero_no_ar", 64'(ar_cnt), 64'd0);
        chk("zero_no_arvalid", 64'(first_arv_cyc), 64'hFFFF_FFFF_FFFF_FFFF);

        // Back-pressure: FIFO full for 10 cycles in the middle of the line.
        clear_logs();
        do_kick(32'h0000_1000, 16'd64);
        wait_writes(20);
        for (int i = 0; i < 10; i++) begin
            fifo_full = 1'b1;
            #1;
            chk($sformatf("full_rready_%0d", i), {63'd0, m_axi_rready}, 64'd0);
            if (i > 0) chk($sformatf("full_wr_en_%0d", i), {63'd0, fifo_wr_en}, 64'd0);
            @(negedge clk);
        end
        fifo_full = 1'b0;
        wait_idle("full_idle");
        chk("full_n_wr", 64'(wr_cnt), 64'd64);
        chk("full_n_ar", 64'(ar_cnt), 64'd4);

        // Kick while busy is ignored.
        clear_logs();
        do_kick(32'h0000_1000, 16'd64);
        repeat (5) @(negedge clk);
        do_kick(32'h0000_2000, 16'd4);
        wait_idle("busy_kick_idle");
        hits = 0;
        for (int k = 0; k < ar_cnt && k < 16; k++) if (ar_addr_log[k] == 32'h2000) hits++;
        chk("busy_kick_no_2000", 64'(hits), 64'd0);
        chk("busy_kick_n_ar", 64'(ar_cnt), 64'd4);
        chk("busy_kick_n_wr", 64'(wr_cnt), 64'd64);

        // Reset in the middle of the R phase, then a clean request.
        clear_logs();
        do_kick(32'h0000_1000, 16'd64);
        wait_writes(10);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vecs[3], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
